// File: rtl/arm_pkg.sv
// ============================================================================
//  Module      : arm_pkg
//  Description : Shared types and constants for the arm_model motion
//                sequencer: opcodes, Q16.16 width, FSM state encoding,
//                program-entry layout, home pose and link lengths.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package arm_pkg;

    // Q16.16 fixed-point word width used for all coordinates and angles
    localparam int c_Q_W = 32;

    // Link lengths of the two-link arm (Q16.16)
    localparam logic [c_Q_W-1:0] c_L1 = 32'h0007_6666;
    localparam logic [c_Q_W-1:0] c_L2 = 32'h0012_0000;

    // Home pose: arm stretched straight up, y = L1 + L2
    localparam logic [c_Q_W-1:0] c_HOME_X = 32'h0000_0000;
    localparam logic [c_Q_W-1:0] c_HOME_Y = 32'h0019_6666;

    // Program step opcodes
    typedef enum logic [1:0] {
        OP_MOVE_XY  = 2'd0,
        OP_MOVE_ANG = 2'd1,
        OP_GRIP     = 2'd2,
        OP_RELEASE  = 2'd3
    } arm_op_e;

    // One program entry: opcode plus two Q16.16 operands (66 bits)
    typedef struct packed {
        arm_op_e          op;
        logic [c_Q_W-1:0] a;
        logic [c_Q_W-1:0] b;
    } prog_entry_t;

    // Sequencer FSM state encoding
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t c_ST_IDLE  = 3'd0;
    localparam seq_state_t c_ST_FETCH = 3'd1;
    localparam seq_state_t c_ST_APPLY = 3'd2;
    localparam seq_state_t c_ST_WAIT  = 3'd3;
    localparam seq_state_t c_ST_DONE  = 3'd4;

    // Moves need the long servo settle time, gripper steps the short one
    function automatic logic op_is_move(input arm_op_e op);
        return (op == OP_MOVE_XY) || (op == OP_MOVE_ANG);
    endfunction

endpackage

`default_nettype wire

// File: rtl/arm_seq_ctrl_if.sv
// ============================================================================
//  Module      : arm_seq_ctrl_if
//  Description : Host-side program/control bus and arm_model-side pose bus
//                of the motion sequencer. Optional macro ARM_SEQ_LOOP_EN
//                adds the 'loop' control signal.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface arm_seq_ctrl_if
    import arm_pkg::*;
#(
    parameter int AW = 4
);
    // Program write port and run control (host -> sequencer)
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [1:0]       wr_op;
    logic [c_Q_W-1:0] wr_a;
    logic [c_Q_W-1:0] wr_b;
    logic [AW:0]      prog_len;
    logic             start;
    logic             abort;
`ifdef ARM_SEQ_LOOP_EN
    logic             loop;
`endif

    // Pose and status (sequencer -> arm_model / host)
    logic [c_Q_W-1:0] x;
    logic [c_Q_W-1:0] y;
    logic             en1;
    logic             en2;
    logic [c_Q_W-1:0] set_xita1;
    logic [c_Q_W-1:0] set_xita2;
    logic             catch;
    logic             busy;
    logic             done;
    logic [AW-1:0]    step_idx;

    // Host side
    modport master (
`ifdef ARM_SEQ_LOOP_EN
        output loop,
`endif
        output wr_en, wr_addr, wr_op, wr_a, wr_b, prog_len, start, abort,
        input  x, y, en1, en2, set_xita1, set_xita2, catch, busy, done, step_idx
    );

    // Sequencer side
    modport slave (
`ifdef ARM_SEQ_LOOP_EN
        input  loop,
`endif
        input  wr_en, wr_addr, wr_op, wr_a, wr_b, prog_len, start, abort,
        output x, y, en1, en2, set_xita1, set_xita2, catch, busy, done, step_idx
    );

endinterface

`default_nettype wire

// File: rtl/arm_seq_prog_ram.sv
// ============================================================================
//  Module      : arm_seq_prog_ram
//  Description : DEPTH x WIDTH program store, one write port and one
//                synchronous read port. Contents survive reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module arm_seq_prog_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 66
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]         i_wdata,
    input  wire logic                     i_re,
    input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic      [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: no reset so the program survives a controller reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Synchronous read port: data appears the cycle after i_re
    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/arm_seq_ctrl.sv
// ============================================================================
//  Module      : arm_seq_ctrl
//  Description : Motion sequencer for the two-link arm_model datapath.
//                Steps through a small program of MOVE_XY / MOVE_ANG /
//                GRIP / RELEASE entries, holding each for a settle time.
//                Optional macro ARM_SEQ_LOOP_EN enables program looping.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module arm_seq_ctrl
    import arm_pkg::*;
#(
    parameter int               DEPTH         = 16,
    parameter int               SETTLE_CYCLES = 10000,
    parameter int               GRIP_CYCLES   = 2000,
    parameter logic [c_Q_W-1:0] HOME_X        = c_HOME_X,
    parameter logic [c_Q_W-1:0] HOME_Y        = c_HOME_Y
) (
    input wire logic      clk,
    input wire logic      rst_n,
    arm_seq_ctrl_if.slave bus
);

    // The interface must be instantiated with AW = clog2(DEPTH)
    localparam int c_AW      = $clog2(DEPTH);
    localparam int c_CNT_MAX = (SETTLE_CYCLES > GRIP_CYCLES) ? SETTLE_CYCLES : GRIP_CYCLES;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_AW:0]   c_DEPTH_LEN  = (c_AW+1)'(DEPTH);
    localparam logic [c_CW-1:0] c_SETTLE_LD  = c_CW'(SETTLE_CYCLES);
    localparam logic [c_CW-1:0] c_GRIP_LD    = c_CW'(GRIP_CYCLES);
    localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    seq_state_t        r_state;
    seq_state_t        w_state_nxt;

    logic [c_AW-1:0]   r_step_idx;
    logic [c_AW-1:0]   r_last;
    logic [c_CW-1:0]   r_cnt;

    logic [c_Q_W-1:0]  r_x;
    logic [c_Q_W-1:0]  r_y;
    logic              r_en1;
    logic              r_en2;
    logic [c_Q_W-1:0]  r_xita1;
    logic [c_Q_W-1:0]  r_xita2;
    logic              r_catch;

    logic              w_busy;
    logic              w_done;
    logic              w_mem_re;
    logic              w_mem_we;

    logic [c_AW:0]     w_len_clamped;
    logic              w_wait_end;
    logic              w_last;
    logic              w_loop;

    logic [$bits(prog_entry_t)-1:0] w_rd_raw;
    prog_entry_t                    w_rd;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    assign w_len_clamped = (bus.prog_len > c_DEPTH_LEN) ? c_DEPTH_LEN : bus.prog_len;
    assign w_wait_end    = (r_cnt <= c_CNT_ONE);
    assign w_last        = (r_step_idx == r_last);
    assign w_rd          = prog_entry_t'(w_rd_raw);

`ifdef ARM_SEQ_LOOP_EN
    assign w_loop = bus.loop;
`else
    assign w_loop = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Program memory
    // ------------------------------------------------------------------
    arm_seq_prog_ram #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(prog_entry_t))
    ) u_prog_ram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (bus.wr_addr),
        .i_wdata ({bus.wr_op, bus.wr_a, bus.wr_b}),
        .i_re    (w_mem_re),
        .i_raddr (r_step_idx),
        .o_rdata (w_rd_raw)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic, abort overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = (w_len_clamped == '0) ? c_ST_DONE : c_ST_FETCH;
                    end
                end
                c_ST_FETCH: w_state_nxt = c_ST_APPLY;
                c_ST_APPLY: w_state_nxt = c_ST_WAIT;
                c_ST_WAIT: begin
                    if (w_wait_end) begin
                        w_state_nxt = (w_last && !w_loop) ? c_ST_DONE : c_ST_FETCH;
                    end
                end
                c_ST_DONE:  w_state_nxt = c_ST_IDLE;
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // FSM: state-decoded status and memory strobes
    always_comb begin
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_mem_re = 1'b0;
        w_mem_we = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_mem_we = bus.wr_en;
            end
            c_ST_FETCH: begin
                w_busy   = 1'b1;
                w_mem_re = 1'b1;
            end
            c_ST_APPLY, c_ST_WAIT: begin
                w_busy = 1'b1;
            end
            c_ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Step index, last-step latch and settle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_idx <= '0;
            r_last     <= '0;
            r_cnt      <= '0;
        end else if (!bus.abort) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_step_idx <= '0;
                        // Zero length never enters FETCH, so the wrap is harmless
                        r_last     <= c_AW'(w_len_clamped - 1'b1);
                    end
                end
                c_ST_APPLY: begin
                    r_cnt <= op_is_move(w_rd.op) ? c_SETTLE_LD : c_GRIP_LD;
                end
                c_ST_WAIT: begin
                    if (!w_wait_end) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_last) begin
                        r_step_idx <= r_step_idx + 1'b1;
                    end else if (w_loop) begin
                        r_step_idx <= '0;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pose registers: loaded in APPLY, sent home on abort
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= HOME_X;
            r_y     <= HOME_Y;
            r_en1   <= 1'b1;
            r_en2   <= 1'b0;
            r_xita1 <= '0;
            r_xita2 <= '0;
            r_catch <= 1'b0;
        end else if (bus.abort) begin
            // Gripper is deliberately held so a carried part is not dropped
            r_x   <= HOME_X;
            r_y   <= HOME_Y;
            r_en1 <= 1'b1;
            r_en2 <= 1'b0;
        end else if (r_state == c_ST_APPLY) begin
            case (w_rd.op)
                OP_MOVE_XY: begin
                    r_x   <= w_rd.a;
                    r_y   <= w_rd.b;
                    r_en1 <= 1'b1;
                    r_en2 <= 1'b0;
                end
                OP_MOVE_ANG: begin
                    r_xita1 <= w_rd.a;
                    r_xita2 <= w_rd.b;
                    r_en1   <= 1'b0;
                    r_en2   <= 1'b1;
                end
                OP_GRIP:    r_catch <= 1'b1;
                OP_RELEASE: r_catch <= 1'b0;
                default:    r_catch <= r_catch;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.en1       = r_en1;
    assign bus.en2       = r_en2;
    assign bus.set_xita1 = r_xita1;
    assign bus.set_xita2 = r_xita2;
    assign bus.catch     = r_catch;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.step_idx  = r_step_idx;

endmodule

`default_nettype wire

// File: tb/tb_arm_seq_ctrl.sv
// ============================================================================
//  Module      : tb_arm_seq_ctrl
//  Description : Self-checking bench for arm_seq_ctrl with short settle
//                times (SETTLE=8, GRIP=4). Loop checks are built only when
//                ARM_SEQ_LOOP_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arm_seq_ctrl;
    import arm_pkg::*;

    localparam int          DEPTH  = 16;
    localparam int          AW     = 4;
    localparam int          SETTLE = 8;
    localparam int          GRIP   = 4;
    localparam logic [31:0] HX     = 32'h0000_0000;
    localparam logic [31:0] HY     = 32'h0019_6666;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arm_seq_ctrl_if #(.AW(AW)) bus ();

    arm_seq_ctrl #(
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (SETTLE),
        .GRIP_CYCLES   (GRIP),
        .HOME_X        (HX),
        .HOME_Y        (HY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    // Count every done pulse, sampled mid-cycle
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [31:0] ex, ey;
        logic        e1, e2;
        logic [31:0] t1, t2;
        logic        c;
        int          wait_cyc;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_op   = op;
        bus.wr_a    = a;
        bus.wr_b    = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Returns #1 after the edge that sampled start
    task automatic go(input logic [AW:0] len);
        bus.prog_len = len;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic chk_pose(input string t, input logic [31:0] ex, input logic [31:0] ey,
                            input logic e1, input logic e2, input logic [31:0] t1,
                            input logic [31:0] t2, input logic c);
        chk({t, ".x"},     bus.x,         ex);
        chk({t, ".y"},     bus.y,         ey);
        chk({t, ".en1"},   32'(bus.en1),  32'(e1));
        chk({t, ".en2"},   32'(bus.en2),  32'(e2));
        chk({t, ".xita1"}, bus.set_xita1, t1);
        chk({t, ".xita2"}, bus.set_xita2, t2);
        chk({t, ".catch"}, 32'(bus.catch), 32'(c));
    endtask

    initial begin
        int d0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_op = '0; bus.wr_a = '0; bus.wr_b = '0;
        bus.prog_len = '0; bus.start = 1'b0; bus.abort = 1'b0;
`ifdef ARM_SEQ_LOOP_EN
        bus.loop = 1'b0;
`endif
        //                op   a             b             ex            ey            e1    e2    t1            t2            c     wait
        tbl[0] = '{2'd0, 32'h0001_0000, 32'h0002_0000, 32'h0001_0000, 32'h0002_0000, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, SETTLE};
        tbl[1] = '{2'd2, 32'h0,        32'h0,        32'h0001_0000, 32'h0002_0000, 1'b1, 1'b0, 32'h0,        32'h0,        1'b1, GRIP};
        tbl[2] = '{2'd1, 32'h005A_0000, 32'hFFD3_0000, 32'h0001_0000, 32'h0002_0000, 1'b0, 1'b1, 32'h005A_0000, 32'hFFD3_0000, 1'b1, SETTLE};
        tbl[3] = '{2'd3, 32'h0,        32'h0,        32'h0001_0000, 32'h0002_0000, 1'b0, 1'b1, 32'h005A_0000, 32'hFFD3_0000, 1'b0, GRIP};
        tbl[4] = '{2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 32'h005A_0000, 32'hFFD3_0000, 1'b0, SETTLE};

        // ---- reset state ----
        tick(2);
        chk_pose("rst", HX, HY, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst.busy", 32'(bus.busy), 32'h0);
        chk("rst.done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst.step_idx", 32'(bus.step_idx), 32'h0);
        chk("post_rst.busy", 32'(bus.busy), 32'h0);

        // ---- single-step table ----
        for (int i = 0; i < 5; i++) begin
            wr('0, tbl[i].op, tbl[i].a, tbl[i].b);
            go(5'd1);
            tick(2);
            chk_pose($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].e1, tbl[i].e2,
                     tbl[i].t1, tbl[i].t2, tbl[i].c);
            chk($sformatf("tbl%0d.busy", i), 32'(bus.busy), 32'h1);
            tick(tbl[i].wait_cyc - 1);
            chk($sformatf("tbl%0d.done_early", i), 32'(bus.done), 32'h0);
            tick();
            chk($sformatf("tbl%0d.done", i), 32'(bus.done), 32'h1);
            chk($sformatf("tbl%0d.busy_done", i), 32'(bus.busy), 32'h0);
            tick();
            chk($sformatf("tbl%0d.done_off", i), 32'(bus.done), 32'h0);
        end

        // ---- move then grip, timing ----
        wr(4'd0, 2'd0, 32'd1277000, 32'd0);
        wr(4'd1, 2'd2, 32'd0, 32'd0);
        d0 = done_cnt;
        go(5'd2);
        chk("s2.x_lat1", bus.x, 32'h7FFF_FFFF);
        tick(2);
        chk("s2.x", bus.x, 32'd1277000);
        chk("s2.y", bus.y, 32'd0);
        tick(9);
        chk("s2.catch_early", 32'(bus.catch), 32'h0);
        tick();
        chk("s2.catch", 32'(bus.catch), 32'h1);
        chk("s2.step_idx", 32'(bus.step_idx), 32'h1);
        tick(3);
        chk("s2.done_early", 32'(bus.done), 32'h0);
        tick();
        chk("s2.done", 32'(bus.done), 32'h1);
        chk("s2.busy", 32'(bus.busy), 32'h0);
        tick();
        chk("s2.done_cnt", 32'(done_cnt - d0), 32'h1);

        // ---- angle move then xy move ----
        wr(4'd0, 2'd1, 32'h000A_0000, 32'h000A_0000);
        wr(4'd1, 2'd0, 32'd342923, 32'd1522571);
        go(5'd2);
        tick(2);
        chk_pose("s3a", 32'd1277000, 32'd0, 1'b0, 1'b1, 32'h000A_0000, 32'h000A_0000, 1'b1);
        tick(10);
        chk_pose("s3b", 32'd342923, 32'd1522571, 1'b1, 1'b0, 32'h000A_0000, 32'h000A_0000, 1'b1);
        tick(8);
        chk("s3.done", 32'(bus.done), 32'h1);
        tick();

        // ---- abort during step 0 WAIT ----
        wr(4'd0, 2'd0, 32'd5, 32'd6);
        wr(4'd1, 2'd3, 32'd0, 32'd0);
        wr(4'd2, 2'd2, 32'd0, 32'd0);
        d0 = done_cnt;
        go(5'd3);
        tick(2);
        chk("s4.x_before", bus.x, 32'd5);
        tick(3);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("s4.busy", 32'(bus.busy), 32'h0);
        chk_pose("s4", HX, HY, 1'b1, 1'b0, 32'h000A_0000, 32'h000A_0000, 1'b1);
        tick(20);
        chk("s4.no_done", 32'(done_cnt - d0), 32'h0);
        chk("s4.busy_late", 32'(bus.busy), 32'h0);
        chk("s4.catch_late", 32'(bus.catch), 32'h1);

        // ---- zero-length program, ignored start / write while busy ----
        go(5'd0);
        chk("s5.done0", 32'(bus.done), 32'h1);
        chk("s5.busy0", 32'(bus.busy), 32'h0);
        chk("s5.x0", bus.x, HX);
        tick();
        chk("s5.done0_off", 32'(bus.done), 32'h0);
        wr(4'd0, 2'd1, 32'h000A_0000, 32'h000A_0000);
        wr(4'd1, 2'd0, 32'd342923, 32'd1522571);
        d0 = done_cnt;
        go(5'd2);
        tick(3);
        bus.start = 1'b1; bus.prog_len = 5'd1;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_op = 2'd0; bus.wr_a = 32'd999; bus.wr_b = 32'd999;
        tick();
        bus.start = 1'b0; bus.wr_en = 1'b0;
        tick(8);
        chk("s5.x", bus.x, 32'd342923);
        chk("s5.y", bus.y, 32'd1522571);
        chk("s5.step_idx", 32'(bus.step_idx), 32'h1);
        tick(7);
        chk("s5.done_early", 32'(bus.done), 32'h0);
        tick();
        chk("s5.done", 32'(bus.done), 32'h1);
        tick();
        chk("s5.done_cnt", 32'(done_cnt - d0), 32'h1);

        // ---- reset mid-WAIT, memory retained ----
        wr(4'd0, 2'd2, 32'd0, 32'd0);
        wr(4'd1, 2'd0, 32'h123, 32'h456);
        go(5'd2);
        tick(8);
        chk("s1.x_run", bus.x, 32'h123);
        tick(2);
        chk("s1.busy_run", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_pose("s1.rst", HX, HY, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("s1.rst.busy", 32'(bus.busy), 32'h0);
        chk("s1.rst.done", 32'(bus.done), 32'h0);
        chk("s1.rst.step_idx", 32'(bus.step_idx), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        go(5'd2);
        tick(2);
        chk("s1.mem_catch", 32'(bus.catch), 32'h1);
        tick(6);
        chk("s1.mem_x", bus.x, 32'h123);
        tick(8);
        chk("s1.done", 32'(bus.done), 32'h1);
        tick();

        // ---- prog_len above DEPTH clamps to DEPTH ----
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 2'd2, 32'd0, 32'd0);
        go(5'd31);
        tick(95);
        chk("clamp.step_idx", 32'(bus.step_idx), 32'd15);
        chk("clamp.done_early", 32'(bus.done), 32'h0);
        tick();
        chk("clamp.done", 32'(bus.done), 32'h1);
        tick();

`ifdef ARM_SEQ_LOOP_EN
        // ---- looping ----
        wr(4'd0, 2'd2, 32'd0, 32'd0);
        wr(4'd1, 2'd3, 32'd0, 32'd0);
        bus.loop = 1'b1;
        d0 = done_cnt;
        go(5'd2);
        for (int k = 0; k < 4; k++) begin
            tick((k == 0) ? 2 : 6);
            chk($sformatf("loop%0d.step_idx", k), 32'(bus.step_idx), 32'(k % 2));
            chk($sformatf("loop%0d.catch", k), 32'(bus.catch), 32'((k % 2) == 0));
            chk($sformatf("loop%0d.busy", k), 32'(bus.busy), 32'h1);
        end
        bus.loop = 1'b0;
        chk("loop.no_done", 32'(done_cnt - d0), 32'h0);
        tick(3);
        chk("loop.done_early", 32'(bus.done), 32'h0);
        tick();
        chk("loop.done", 32'(bus.done), 32'h1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
